comp_conv_pipe: RTL and testbench
=================================

// Module: comp_conv_pipe
// PURPOSE
//  Pipelined, multi-lane sign-magnitude -> 2's complement converter for systolic-array products.
//  Each lane splits into 1x DW, 2x DW/2 or 4x DW/4 subfields by mode; no carry crosses subfields.
//  Sits between the PE multiplier outputs and the accumulators; valid/ready on both sides.
// PARAMETERS
//  LANES  4   number of independent DW-bit lanes per beat
//  DW     32  lane width; must be a multiple of 4 and >= 8
// PORTS
//  clk        in   1        single clock; all state on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        converter can accept a beat
//  in_mode    in   2        00 full DW, 01 two DW/2, 10 four DW/4, 11 reserved (treated as 00)
//  in_data    in   LANES*DW magnitudes, lane l = in_data[l*DW +: DW]
//  in_sign    in   LANES*4  product signs (already XORed); lane l subfield k = in_sign[l*4+k]
//  out_valid  out  1        output beat valid
//  out_ready  in   1        downstream accepts
//  out_data   out  LANES*DW 2's complement results, same lane/subfield layout
//  out_ovf    out  LANES*4  per-subfield overflow flag (present only with COMP_SAT_EN)
// BEHAVIOUR
//  - Subfield k of width n: result = sign ? (~mag + 1) mod 2^n : mag. Full mode uses sign bit 0 only;
//    half mode bits 0 (low), 1 (high); quarter bits 0..3 (LSB subfield first). Unused sign bits ignored.
//  - Mode travels with its beat; mixed modes on consecutive beats are legal.
//  - Stage 1 (S1): register conditionally inverted data, per-subfield +1 vector, mode, signs.
//  - Stage 2 (S2): segmented add (carry killed at every active subfield boundary), drive out_*.
//  - Latency exactly 2 cycles from accepted input to out_valid with no backpressure; throughput 1/cycle.
//  - Handshake: s2_adv = ~out_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv.
//    Beat accepted on in_valid & in_ready; output retired on out_valid & out_ready.
//  - out_data/out_ovf held stable while out_valid & ~out_ready; no beat dropped or duplicated.
//  - Accept and retire in the same cycle with both stages full: pipe shifts, stays full.
//  - mag = 0 with sign = 1 yields 0; the carry out of the subfield is discarded, never propagated.
//  - Reset: out_valid=0, out_data=0, out_ovf=0, s1_valid=0; in_ready=1 the cycle after rst deasserts.
//    Reset mid-operation discards all in-flight beats.
// CONFIGURATION
//  COMP_SAT_EN defined: per subfield, sign=1 & mag > 2^(n-1) -> result 2^(n-1) (most negative),
//    ovf=1; sign=0 & mag[n-1]=1 -> result 2^(n-1)-1, ovf=1; else ovf=0. Detection in S1, muxing in S2;
//    latency unchanged.
//  COMP_SAT_EN undefined: plain wrap-around result, out_ovf port and its logic absent.
// STRUCTURE
//  - comp_pkg: mode encodings (MODE_FULL, MODE_HALF, MODE_QUAR), subfield count/width functions.
//  - Sub-module comp_lane: one DW lane, combinational invert and segmented add. The top generates LANES
//    instances split across S1/S2 and owns the pipeline registers and handshake.
// TESTING (DW=32, LANES=4; lane 0 shown, other lanes randomised and checked vs model)
//  1 full, data=0x00000005 sign=0001 -> 0xFFFFFFFB two cycles later; sign=0 -> 0x00000005.
//  2 half, data=0x00030002 sign=0011 -> 0xFFFDFFFE; data=0x00000000 sign=0001 -> 0x00000000
//    (no carry into the high half).
//  3 quarter, data=0x01020304 sign=0101 -> 0x01FE03FC; back-to-back modes full/half/quarter,
//    each result matches its own mode.
//  4 backpressure: stream 8 beats, out_ready low for 3 cycles mid-stream -> in_ready drops once
//    both stages are full; output order intact, data stable while stalled.
//  5 rst asserted with 2 beats in flight -> out_valid=0 next cycle, no stale beat emerges afterwards.
//  6 COMP_SAT_EN: full, 0x80000001 sign=1 -> 0x80000000 ovf[0]=1; 0x80000000 sign=0 ->
//    0x7FFFFFFF ovf=1. Without the macro: 0x7FFFFFFF and 0x80000000, no ovf port.

Source files
------------

// File: rtl/comp_pkg.sv
// Mode encodings and subfield geometry helpers shared by comp_conv_pipe and comp_lane.
package comp_pkg;

  typedef enum logic [1:0] {
    MODE_FULL = 2'b00,
    MODE_HALF = 2'b01,
    MODE_QUAR = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Maximum subfields per lane; also the number of sign/ovf bits per lane.
  localparam int unsigned NSUB = 4;

  // The reserved encoding falls through to full-width behaviour.
  function automatic int unsigned sub_count(mode_e m);
    case (m)
      MODE_HALF: return 2;
      MODE_QUAR: return 4;
      default:   return 1;
    endcase
  endfunction

  function automatic int unsigned sub_width(mode_e m, int unsigned dw);
    return dw / sub_count(m);
  endfunction

  // Subfield index that owns quarter q of a lane.
  function automatic logic [1:0] sub_of(mode_e m, int unsigned q);
    return 2'(q / (NSUB / sub_count(m)));
  endfunction

  // True when quarter q holds the LSBs of its subfield.
  function automatic logic sub_start(mode_e m, int unsigned q);
    return (q % (NSUB / sub_count(m))) == 0;
  endfunction

endpackage

// File: rtl/comp_lane.sv
// One DW-bit lane: S1-side conditional invert (+ saturation detect with COMP_SAT_EN),
// S2-side segmented increment. Purely combinational; the top owns the pipeline registers.
module comp_lane
  import comp_pkg::*;
#(
  parameter int DW = 32
) (
  input  mode_e           s1_mode,
  input  logic [DW-1:0]   s1_mag,
  input  logic [NSUB-1:0] s1_sign,
  output logic [DW-1:0]   s1_inv,
  output logic [NSUB-1:0] s1_inc,
`ifdef COMP_SAT_EN
  output logic [NSUB-1:0] s1_ovf,
  input  logic [NSUB-1:0] s2_sign,
  input  logic [NSUB-1:0] s2_ovf,
`endif
  input  mode_e           s2_mode,
  input  logic [DW-1:0]   s2_inv,
  input  logic [NSUB-1:0] s2_inc,
  output logic [DW-1:0]   s2_res
);

  localparam int Q = DW / 4;
  localparam int H = DW / 2;

  logic [DW-1:0] sum;
  logic          carry;
  logic          cin;

  // The +1 of each negative subfield is injected only at that subfield's LSB quarter.
  always_comb begin : s1_invert
    s1_inv = '0;
    s1_inc = '0;
    for (int q = 0; q < NSUB; q++) begin
      s1_inv[q*Q +: Q] = s1_sign[sub_of(s1_mode, q)] ? ~s1_mag[q*Q +: Q] : s1_mag[q*Q +: Q];
      s1_inc[q]        = sub_start(s1_mode, q) & s1_sign[sub_of(s1_mode, q)];
    end
  end

  // Carry ripples between quarters inside a subfield and is replaced at every subfield start.
  always_comb begin : s2_add
    carry = 1'b0;
    cin   = 1'b0;
    sum   = '0;
    for (int q = 0; q < NSUB; q++) begin
      cin = sub_start(s2_mode, q) ? s2_inc[q] : carry;
      {carry, sum[q*Q +: Q]} = {1'b0, s2_inv[q*Q +: Q]} + (Q+1)'(cin);
    end
  end

`ifdef COMP_SAT_EN
  // Overflow: magnitude MSB set, unless negative and exactly 2^(n-1).
  always_comb begin : s1_sat_detect
    s1_ovf = '0;
    case (s1_mode)
      MODE_HALF:
        for (int k = 0; k < 2; k++)
          s1_ovf[k] = s1_mag[k*H+H-1] & (~s1_sign[k] | (|s1_mag[k*H +: H-1]));
      MODE_QUAR:
        for (int k = 0; k < 4; k++)
          s1_ovf[k] = s1_mag[k*Q+Q-1] & (~s1_sign[k] | (|s1_mag[k*Q +: Q-1]));
      default:
        s1_ovf[0] = s1_mag[DW-1] & (~s1_sign[0] | (|s1_mag[DW-2:0]));
    endcase
  end

  always_comb begin : s2_sat_mux
    s2_res = sum;
    case (s2_mode)
      MODE_HALF:
        for (int k = 0; k < 2; k++)
          if (s2_ovf[k]) s2_res[k*H +: H] = {s2_sign[k], {(H-1){~s2_sign[k]}}};
      MODE_QUAR:
        for (int k = 0; k < 4; k++)
          if (s2_ovf[k]) s2_res[k*Q +: Q] = {s2_sign[k], {(Q-1){~s2_sign[k]}}};
      default:
        if (s2_ovf[0]) s2_res = {s2_sign[0], {(DW-1){~s2_sign[0]}}};
    endcase
  end
`else
  assign s2_res = sum;
`endif

endmodule

// File: rtl/comp_conv_pipe.sv
// Two-stage multi-lane sign-magnitude -> 2's complement converter with valid/ready on both sides.
// Optional saturation with per-subfield overflow flags when COMP_SAT_EN is defined.
module comp_conv_pipe
  import comp_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic [LANES*NSUB-1:0] in_sign,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data
`ifdef COMP_SAT_EN
  ,
  output logic [LANES*NSUB-1:0] out_ovf
`endif
);

  logic                  s1_valid;
  logic                  s1_adv;
  logic                  s2_adv;
  mode_e                 s1_mode;
  logic [LANES*DW-1:0]   s1_inv;
  logic [LANES*NSUB-1:0] s1_inc;
  logic [LANES*DW-1:0]   lane_inv;
  logic [LANES*NSUB-1:0] lane_inc;
  logic [LANES*DW-1:0]   lane_res;
`ifdef COMP_SAT_EN
  logic [LANES*NSUB-1:0] s1_sign;
  logic [LANES*NSUB-1:0] s1_ovf;
  logic [LANES*NSUB-1:0] lane_ovf;
`endif

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk) begin : ctrl_regs
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid  <= in_valid;
      if (s2_adv) out_valid <= s1_valid;
    end
  end

  // NOTE: S1 payload is qualified by s1_valid, so it carries no reset and only loads on accept.
  always_ff @(posedge clk) begin : s1_regs
    if (s1_adv && in_valid) begin
      s1_mode <= mode_e'(in_mode);
      s1_inv  <= lane_inv;
      s1_inc  <= lane_inc;
`ifdef COMP_SAT_EN
      s1_sign <= in_sign;
      s1_ovf  <= lane_ovf;
`endif
    end
  end

  always_ff @(posedge clk) begin : s2_regs
    if (rst) begin
      out_data <= '0;
`ifdef COMP_SAT_EN
      out_ovf  <= '0;
`endif
    end else if (s2_adv && s1_valid) begin
      out_data <= lane_res;
`ifdef COMP_SAT_EN
      out_ovf  <= s1_ovf;
`endif
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    comp_lane #(.DW(DW)) u_lane (
      .s1_mode (mode_e'(in_mode)),
      .s1_mag  (in_data[l*DW +: DW]),
      .s1_sign (in_sign[l*NSUB +: NSUB]),
      .s1_inv  (lane_inv[l*DW +: DW]),
      .s1_inc  (lane_inc[l*NSUB +: NSUB]),
`ifdef COMP_SAT_EN
      .s1_ovf  (lane_ovf[l*NSUB +: NSUB]),
      .s2_sign (s1_sign[l*NSUB +: NSUB]),
      .s2_ovf  (s1_ovf[l*NSUB +: NSUB]),
`endif
      .s2_mode (s1_mode),
      .s2_inv  (s1_inv[l*DW +: DW]),
      .s2_inc  (s1_inc[l*NSUB +: NSUB]),
      .s2_res  (lane_res[l*DW +: DW])
    );
  end

endmodule

// File: tb/tb_comp_conv_pipe.sv
// Self-checking bench for comp_conv_pipe: directed lane-0 vectors plus randomised lanes,
// scored against an arithmetic reference model. Honours COMP_SAT_EN when defined.
module tb_comp_conv_pipe;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int LW    = LANES * DW;
  localparam int SW    = LANES * 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [LW-1:0] in_data;
  logic [SW-1:0] in_sign;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_data;
`ifdef COMP_SAT_EN
  logic [SW-1:0] out_ovf;
`endif

  typedef struct {
    logic [LW-1:0] data;
    logic [SW-1:0] ovf;
  } beat_t;

  beat_t         sb[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic          stalled  = 1'b0;
  logic [LW-1:0] held;
  logic          accepted;
  logic          saw_block;
  int            sent;

  comp_conv_pipe #(.LANES(LANES), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef COMP_SAT_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: each subfield is negated modulo 2^n when its sign is set, independently.
  function automatic beat_t model(logic [1:0] mode, logic [LW-1:0] d, logic [SW-1:0] s);
    beat_t           r;
    int              c;
    int              n;
    longint unsigned mag, res, full, half;
    logic [LW-1:0]   sh;
    c    = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
    n    = DW / c;
    full = 64'd1 << n;
    half = full >> 1;
    r.data = '0;
    r.ovf  = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < c; k++) begin
        sh  = d >> (l*DW + k*n);
        mag = 64'(sh[31:0]) & (full - 1);
        res = s[l*4+k] ? (full - mag) % full : mag;
`ifdef COMP_SAT_EN
        if (s[l*4+k] && mag > half) begin
          res = half;
          r.ovf[l*4+k] = 1'b1;
        end else if (!s[l*4+k] && mag >= half) begin
          res = half - 1;
          r.ovf[l*4+k] = 1'b1;
        end
`endif
        r.data = r.data | (LW'(res) << (l*DW + k*n));
      end
    end
    return r;
  endfunction

  task automatic drive(logic [1:0] mode, logic [31:0] d0, logic [3:0] s0);
    in_valid = 1'b1;
    in_mode  = mode;
    for (int l = 1; l < LANES; l++) begin
      in_data[l*DW +: DW] = $urandom;
      in_sign[l*4 +: 4]   = 4'($urandom);
    end
    in_data[31:0] = d0;
    in_sign[3:0]  = s0;
  endtask

  task automatic drive_rand();
    drive(2'($urandom_range(0, 3)), $urandom, 4'($urandom));
  endtask

  // One clock: score handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    beat_t e;
    @(negedge clk);
    if (stalled) check("hold stable", 128'(out_data), 128'(held));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("stray beat", 128'(out_valid), 128'(0));
      end else begin
        e = sb.pop_front();
        check("out_data", 128'(out_data), 128'(e.data));
`ifdef COMP_SAT_EN
        check("out_ovf", 128'(out_ovf), 128'(e.ovf));
`endif
      end
    end
    stalled  = out_valid && !out_ready;
    held     = out_data;
    accepted = in_valid && in_ready;
    if (in_valid && !in_ready) saw_block = 1'b1;
    if (accepted) sb.push_back(model(in_mode, in_data, in_sign));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(string tag, logic [1:0] mode, logic [31:0] d0, logic [3:0] s0,
                          logic [31:0] exp0);
    drive(mode, d0, s0);
    cycle();
    in_valid = 1'b0;
    check({tag, " early"}, 128'(out_valid), 128'(0));
    cycle();
    check({tag, " valid"}, 128'(out_valid), 128'(1));
    check(tag, 128'(out_data[31:0]), 128'(exp0));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_data   = '0;
    in_sign   = '0;
    out_ready = 1'b1;
    saw_block = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst out_data", 128'(out_data), 128'(0));
    check("rst in_ready", 128'(in_ready), 128'(1));
`ifdef COMP_SAT_EN
    check("rst out_ovf", 128'(out_ovf), 128'(0));
`endif

    directed("full neg", 2'b00, 32'h0000_0005, 4'b0001, 32'hFFFF_FFFB); cycle();
    directed("full pos", 2'b00, 32'h0000_0005, 4'b0000, 32'h0000_0005); cycle();
    directed("half neg", 2'b01, 32'h0003_0002, 4'b0011, 32'hFFFD_FFFE); cycle();
    directed("half zero", 2'b01, 32'h0000_0000, 4'b0001, 32'h0000_0000); cycle();
    directed("quar mix", 2'b10, 32'h0102_0304, 4'b0101, 32'h01FE_03FC); cycle();
    directed("quar zero", 2'b10, 32'h0000_0000, 4'b1111, 32'h0000_0000); cycle();
    directed("rsvd full", 2'b11, 32'h0000_0005, 4'b1110, 32'h0000_0005); cycle();
`ifdef COMP_SAT_EN
    directed("sat neg", 2'b00, 32'h8000_0001, 4'b0001, 32'h8000_0000);
    check("sat neg ovf", 128'(out_ovf[0]), 128'(1));
    cycle();
    directed("sat pos", 2'b00, 32'h8000_0000, 4'b0000, 32'h7FFF_FFFF);
    check("sat pos ovf", 128'(out_ovf[0]), 128'(1));
    cycle();
`else
    directed("wrap neg", 2'b00, 32'h8000_0001, 4'b0001, 32'h7FFF_FFFF); cycle();
    directed("wrap pos", 2'b00, 32'h8000_0000, 4'b0000, 32'h8000_0000); cycle();
`endif

    // Back-to-back mode changes: each beat converts under its own mode.
    drive(2'b00, 32'h0000_0005, 4'b0001); cycle();
    drive(2'b01, 32'h0003_0002, 4'b0011); cycle();
    check("b2b full", 128'(out_data[31:0]), 128'(32'hFFFF_FFFB));
    drive(2'b10, 32'h0102_0304, 4'b0101); cycle();
    check("b2b half", 128'(out_data[31:0]), 128'(32'hFFFD_FFFE));
    in_valid = 1'b0;
    cycle();
    check("b2b quar", 128'(out_data[31:0]), 128'(32'h01FE_03FC));
    cycle();

    // Backpressure: 8-beat stream with a 3-cycle downstream stall.
    saw_block = 1'b0;
    sent      = 0;
    for (int i = 0; i < 40 && (sent < 8 || sb.size() > 0); i++) begin
      if (sent < 8) drive_rand();
      else in_valid = 1'b0;
      out_ready = !(i >= 3 && i < 6);
      cycle();
      if (accepted) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp in_ready drop", 128'(saw_block), 128'(1));
    check("bp beats sent", 128'(sent), 128'(8));
    check("bp drained", 128'(sb.size()), 128'(0));

    // Random traffic with random backpressure, then a bounded drain.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) drive_rand();
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
    check("rand drained", 128'(sb.size()), 128'(0));

    // Reset with two beats in flight discards both.
    out_ready = 1'b0;
    drive_rand(); cycle();
    drive_rand(); cycle();
    in_valid = 1'b0;
    check("pre-rst full", 128'(out_valid), 128'(1));
    rst = 1'b1;
    cycle();
    check("rst flush", 128'(out_valid), 128'(0));
    sb.delete();
    stalled   = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("post-rst in_ready", 128'(in_ready), 128'(1));
    repeat (5) cycle();
    check("no stale beat", 128'(out_valid), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
